// File: rtl/peak_dbg_ar_master.sv
// Debug command to register-file access-port master: halts the core, then performs one AR read or write.
// Optional halt-wait timeout is compiled in with `define PEAK_DBG_TIMEOUT_EN.
`timescale 1ns/1ps
module peak_dbg_ar_master #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WR,
  input  logic [15:0] CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        HALT_REQ,
  input  logic        HALTED,
  output logic        AR_EN,
  output logic        AR_WR,
  output logic [15:0] AR_AD,
  output logic [31:0] AR_DI,
  input  logic [31:0] AR_DO
);

  localparam logic [7:0] REGION = 8'h10;

  typedef enum logic [2:0] {IDLE, HALT, WR, RD0, RD1, RSP} state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        halt_req_q, halt_req_d;
  logic        ar_en_q, ar_en_d;
  logic        ar_wr_q, ar_wr_d;
  logic [15:0] ar_ad_q, ar_ad_d;
  logic [31:0] ar_di_q, ar_di_d;
`ifdef PEAK_DBG_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`else
  // Without the timeout the limit has no effect; HALT waits for HALTED forever.
  if (TIMEOUT == 8'd0) begin : g_timeout_unused
  end
`endif

  // AR_AD/AR_DI double as the latched command address and write data.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    halt_req_d  = halt_req_q;
    ar_ad_d     = ar_ad_q;
    ar_di_d     = ar_di_q;
`ifdef PEAK_DBG_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (CMD_VALID && cmd_ready_q) begin
          if (CMD_ADDR[15:8] != REGION) begin
            state_d     = RSP;
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d    = HALT;
            wr_d       = CMD_WR;
            ar_ad_d    = CMD_ADDR;
            ar_di_d    = CMD_WDATA;
            halt_req_d = 1'b1;
`ifdef PEAK_DBG_TIMEOUT_EN
            cnt_d      = 8'd0;
`endif
          end
        end
      end
      HALT: begin
        if (HALTED) begin
          state_d = wr_q ? WR : RD0;
        end else begin
`ifdef PEAK_DBG_TIMEOUT_EN
          cnt_d = 8'(cnt_q + 8'd1);
          if (cnt_d == TIMEOUT) begin
            state_d     = RSP;
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b1;
          end
`endif
        end
      end
      WR: begin
        state_d     = RSP;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
      end
      RD0: state_d = RD1;
      RD1: begin
        state_d     = RSP;
        rsp_rdata_d = AR_DO;
        rsp_err_d   = 1'b0;
      end
      RSP: begin
        if (RSP_READY) begin
          state_d    = IDLE;
          halt_req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Level outputs follow the next state so they are registered alongside it.
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
    ar_en_d     = (state_d == WR) || (state_d == RD0) || (state_d == RD1);
    ar_wr_d     = (state_d == WR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      halt_req_q  <= 1'b0;
      ar_en_q     <= 1'b0;
      ar_wr_q     <= 1'b0;
      ar_ad_q     <= 16'd0;
      ar_di_q     <= 32'd0;
`ifdef PEAK_DBG_TIMEOUT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      halt_req_q  <= halt_req_d;
      ar_en_q     <= ar_en_d;
      ar_wr_q     <= ar_wr_d;
      ar_ad_q     <= ar_ad_d;
      ar_di_q     <= ar_di_d;
`ifdef PEAK_DBG_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign CMD_READY = cmd_ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;
  assign HALT_REQ  = halt_req_q;
  assign AR_EN     = ar_en_q;
  assign AR_WR     = ar_wr_q;
  assign AR_AD     = ar_ad_q;
  assign AR_DI     = ar_di_q;

endmodule

// File: tb/tb_peak_dbg_ar_master.sv
// Scoreboard bench for peak_dbg_ar_master: directed scenarios plus randomized command traffic.
`timescale 1ns/1ps
module tb_peak_dbg_ar_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CMD_VALID = 1'b0, CMD_READY, CMD_WR = 1'b0;
  logic [15:0] CMD_ADDR = 16'd0;
  logic [31:0] CMD_WDATA = 32'd0;
  logic        RSP_VALID, RSP_READY = 1'b0, RSP_ERR;
  logic [31:0] RSP_RDATA;
  logic        HALT_REQ, HALTED = 1'b0, AR_EN, AR_WR;
  logic [15:0] AR_AD;
  logic [31:0] AR_DI;
  logic [31:0] AR_DO = 32'd0;

  always #5 CLK = ~CLK;

  peak_dbg_ar_master #(.TIMEOUT(8'd4)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .HALT_REQ(HALT_REQ), .HALTED(HALTED),
    .AR_EN(AR_EN), .AR_WR(AR_WR), .AR_AD(AR_AD), .AR_DI(AR_DI), .AR_DO(AR_DO)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        halt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e, held;
  logic        stall = 1'b0;
  int          checks = 0, errors = 0;
  int          n_arw = 0, n_arr = 0, n_halt = 0;
  logic [15:0] cur_addr = 16'd0, last_wr_ad = 16'd0;
  logic [31:0] cur_wdata = 32'd0, last_wr_di = 32'd0;
  logic        rnd_en = 1'b0;
  logic [31:0] tb_mem  [logic [15:0]];
  logic [31:0] ref_mem [logic [15:0]];

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {a, ~a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: region 0x10 goes to a flat register map, anything else is rejected.
  function automatic exp_t ref_access(input logic wr, input logic [15:0] addr, input logic [31:0] wdata);
    exp_t e;
    if (addr[15:8] != 8'h10) begin
      e = '{rdata: 32'd0, err: 1'b1, halt: 1'b0};
    end else if (wr) begin
      ref_mem[addr] = wdata;
      e = '{rdata: 32'd0, err: 1'b0, halt: 1'b1};
    end else begin
      e = '{rdata: (ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr)), err: 1'b0, halt: 1'b1};
    end
    return e;
  endfunction

  // Register file seen by the AR port: registered read data.
  always @(posedge CLK) begin
    if (AR_EN) begin
      if (AR_WR) tb_mem[AR_AD] = AR_DI;
      else       AR_DO <= tb_mem.exists(AR_AD) ? tb_mem[AR_AD] : dflt(AR_AD);
    end
  end

  // AR port monitor.
  always @(negedge CLK) begin
    if (AR_WR && !AR_EN) begin
      checks++; errors++;
      $display("FAIL ar_wr_without_en: got AR_WR=1 expected AR_EN=1");
    end
    if (AR_EN) begin
      check("ar_ad", 32'(AR_AD), 32'(cur_addr));
      if (AR_WR) begin
        check("ar_di", AR_DI, cur_wdata);
        last_wr_ad = AR_AD;
        last_wr_di = AR_DI;
        n_arw++;
      end else begin
        n_arr++;
      end
    end
    if (HALT_REQ) n_halt++;
  end

  // Response monitor: pops the scoreboard on each handshake and checks hold-stability.
  always @(negedge CLK) begin
    if (RST) begin
      stall = 1'b0;
    end else if (RSP_VALID) begin
      if (stall) begin
        check("rsp_hold_rdata", RSP_RDATA, held.rdata);
        check("rsp_hold_err", 32'(RSP_ERR), 32'(held.err));
        check("rsp_hold_halt", 32'(HALT_REQ), 32'd1 & 32'(held.halt));
      end
      if (RSP_READY) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got rdata %h err %b expected no response", RSP_RDATA, RSP_ERR);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_rdata", RSP_RDATA, mon_e.rdata);
          check("rsp_err", 32'(RSP_ERR), 32'(mon_e.err));
          check("rsp_halt_req", 32'(HALT_REQ), 32'(mon_e.halt));
        end
        stall = 1'b0;
      end else begin
        stall = 1'b1;
        held  = '{rdata: RSP_RDATA, err: RSP_ERR, halt: HALT_REQ};
      end
    end else begin
      stall = 1'b0;
    end
  end

  // Random HALTED / RSP_READY during the random phase.
  always @(posedge CLK) begin
    if (rnd_en) begin
      #1;
`ifdef PEAK_DBG_TIMEOUT_EN
      HALTED = 1'b1;
`else
      HALTED = ($urandom_range(0, 3) != 0);
`endif
      RSP_READY = ($urandom_range(0, 2) != 0);
    end
  end

  // Called just after a posedge; returns just after the accept edge.
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [31:0] wdata);
    int n;
    n = 0;
    CMD_VALID = 1'b1; CMD_WR = wr; CMD_ADDR = addr; CMD_WDATA = wdata;
    forever begin
      @(negedge CLK);
      n++;
      if (CMD_READY) break;
      if (n > 300) break;
    end
    if (!CMD_READY) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout: got CMD_READY=0 expected 1 within 300 cycles");
      @(posedge CLK);
    end else begin
      @(posedge CLK);
      cur_addr  = addr;
      cur_wdata = wdata;
      sb.push_back(ref_access(wr, addr, wdata));
    end
    #1;
    CMD_VALID = 1'b0;
    CMD_WDATA = $urandom;
  endtask

  // Counts edges from the accept edge until RSP_VALID is seen high.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!RSP_VALID && lat < 100);
    if (!RSP_VALID) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got RSP_VALID=0 expected 1 within 100 cycles");
    end
  endtask

  initial begin
    int lat, a0, a1, h0, cnt;
    logic        wr;
    logic [7:0]  reg_hi;
    logic [15:0] addr;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_cmd_ready", 32'(CMD_READY), 32'd0);
    check("reset_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("reset_halt_req", 32'(HALT_REQ), 32'd0);
    check("reset_ar_en", 32'(AR_EN), 32'd0);
    check("reset_ar_ad", 32'(AR_AD), 32'd0);
    check("reset_rsp_rdata", RSP_RDATA, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("cmd_ready_before_edge", 32'(CMD_READY), 32'd0);
    @(posedge CLK); #1;
    check("cmd_ready_after_reset", 32'(CMD_READY), 32'd1);

    // Write with the core already halted.
    HALTED = 1'b1; RSP_READY = 1'b1;
    a0 = n_arw;
    issue(1'b1, 16'h1005, 32'hDEADBEEF);
    wait_rsp(lat);
    check("write_latency", 32'(lat), 32'd3);
    @(posedge CLK); #1;
    check("write_ar_cycles", 32'(n_arw - a0), 32'd1);
    check("write_ar_ad", 32'(last_wr_ad), 32'h1005);
    check("write_ar_di", last_wr_di, 32'hDEADBEEF);

    // Read of a preloaded register.
    tb_mem[16'h1003] = 32'h12345678;
    ref_mem[16'h1003] = 32'h12345678;
    a0 = n_arr;
    issue(1'b0, 16'h1003, 32'd0);
    wait_rsp(lat);
    check("read_latency", 32'(lat), 32'd4);
    check("read_rdata", RSP_RDATA, 32'h12345678);
    @(posedge CLK); #1;
    check("read_ar_cycles", 32'(n_arr - a0), 32'd2);

    // Out-of-region command.
    a0 = n_arw + n_arr; h0 = n_halt;
    issue(1'b1, 16'h2001, 32'h0BAD0BAD);
    wait_rsp(lat);
    check("bad_region_err", 32'(RSP_ERR), 32'd1);
    check("bad_region_rdata", RSP_RDATA, 32'd0);
    @(posedge CLK); #1;
    check("bad_region_no_ar", 32'(n_arw + n_arr - a0), 32'd0);
    check("bad_region_no_halt", 32'(n_halt - h0), 32'd0);

    // Response back-pressure.
    RSP_READY = 1'b0;
    issue(1'b1, 16'h1010, 32'hCAFEF00D);
    wait_rsp(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("bp_rsp_valid", 32'(RSP_VALID), 32'd1);
      check("bp_halt_req", 32'(HALT_REQ), 32'd1);
      check("bp_cmd_ready", 32'(CMD_READY), 32'd0);
    end
    @(posedge CLK); #1;
    RSP_READY = 1'b1;
    @(negedge CLK);
    check("bp_cmd_ready_at_hs", 32'(CMD_READY), 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("bp_rsp_valid_after", 32'(RSP_VALID), 32'd0);
    check("bp_cmd_ready_after", 32'(CMD_READY), 32'd1);
    check("bp_halt_req_after", 32'(HALT_REQ), 32'd0);
    @(posedge CLK); #1;

    // Core never halts.
    HALTED = 1'b0;
    a0 = n_arw + n_arr;
    issue(1'b0, 16'h1007, 32'd0);
`ifdef PEAK_DBG_TIMEOUT_EN
    void'(sb.pop_back());
    sb.push_back('{rdata: 32'd0, err: 1'b1, halt: 1'b1});
    wait_rsp(lat);
    check("timeout_latency", 32'(lat), 32'd5);
    check("timeout_err", 32'(RSP_ERR), 32'd1);
    @(posedge CLK); #1;
    check("timeout_no_ar", 32'(n_arw + n_arr - a0), 32'd0);
`else
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (RSP_VALID || AR_EN) cnt++;
    end
    check("no_timeout_quiet", 32'(cnt), 32'd0);
    check("no_timeout_halt_req", 32'(HALT_REQ), 32'd1);
    @(posedge CLK); #1;
    HALTED = 1'b1;
    wait_rsp(lat);
    @(posedge CLK); #1;
    check("no_timeout_late_ar", 32'(n_arw + n_arr - a0), 32'd2);
`endif

    // Reset during RD1.
    HALTED = 1'b1;
    issue(1'b0, 16'h1002, 32'd0);
    repeat (3) @(negedge CLK);
    check("rd1_ar_en", 32'(AR_EN), 32'd1);
    RST = 1'b1;
    #1;
    check("abort_ar_en", 32'(AR_EN), 32'd0);
    check("abort_halt_req", 32'(HALT_REQ), 32'd0);
    sb.delete();
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("abort_cmd_ready_before", 32'(CMD_READY), 32'd0);
    @(posedge CLK); #1;
    check("abort_cmd_ready_after", 32'(CMD_READY), 32'd1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (RSP_VALID) cnt++;
    end
    check("abort_no_rsp", 32'(cnt), 32'd0);
    @(posedge CLK); #1;

    // Randomized traffic with a small address set to get read-after-write hits.
    rnd_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
      wr     = 1'($urandom);
      reg_hi = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'h10;
      addr   = {reg_hi, 3'b000, 5'($urandom_range(0, 7))};
      issue(wr, addr, $urandom);
    end
    rnd_en = 1'b0;
    @(posedge CLK); #2;
    RSP_READY = 1'b1;
    HALTED = 1'b1;
    cnt = 0;
    while (sb.size() != 0 && cnt < 200) begin
      @(negedge CLK);
      cnt++;
    end
    repeat (2) @(negedge CLK);
    check("drain_scoreboard", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/peak_dbg_ar_master.md
PEAK_DBG_AR_MASTER -- requirements
Module: peak_dbg_ar_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8'd255, halt-wait limit in cycles (used only when PEAK_DBG_TIMEOUT_EN is defined).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports listed in REQ-003 to REQ-018.
REQ-003 CLK  input  1  sole clock, rising edge.
REQ-004 RST  input  1  asynchronous active-high reset.
REQ-005 CMD_VALID  input  1  debug command present.
REQ-006 CMD_READY  output  1  command accepted on CLK edge when CMD_VALID & CMD_READY.
REQ-007 CMD_WR  input  1  1 = register write, 0 = register read.
REQ-008 CMD_ADDR  input  16  target address; [15:8] region, [4:0] register index.
REQ-009 CMD_WDATA  input  32  write data.
REQ-010 RSP_VALID  output  1  response present.
REQ-011 RSP_READY  input  1  response consumed on CLK edge when RSP_VALID & RSP_READY.
REQ-012 RSP_RDATA  output  32  read data; 0 for writes and errors.
REQ-013 RSP_ERR  output  1  command rejected or timed out.
REQ-014 HALT_REQ  output  1  request core stall so the AR port owns the register-file write path.
REQ-015 HALTED  input  1  core stalled, AR access safe.
REQ-016 AR_EN  output  1  register-file debug access enable.
REQ-017 AR_WR  output  1  debug write strobe; AR_AD  output  16  address; AR_DI  output  32  write data.
REQ-018 AR_DO  input  32  register-file read data, valid one cycle after AR_EN with AR_WR=0.

Function
REQ-019 States SHALL be IDLE, HALT, WR, RD0, RD1, RSP; CMD_READY=1 only in IDLE; all outputs SHALL be registered.
REQ-020 On accept, if CMD_ADDR[15:8]!=8'h10, the block SHALL go to RSP with RSP_ERR=1, RSP_RDATA=0, no HALT_REQ, and no AR_EN pulse.
REQ-021 On a valid accept, the block SHALL latch CMD_WR/ADDR/WDATA, enter HALT, and assert HALT_REQ the following cycle.
REQ-022 In HALT with HALTED=1 sampled, the next state SHALL be WR (CMD_WR=1) or RD0 (CMD_WR=0); HALTED=0 SHALL keep HALT.
REQ-023 WR SHALL drive AR_EN=1, AR_WR=1, AR_AD=latched addr, AR_DI=latched data for exactly one cycle, then enter RSP with RSP_RDATA=0, RSP_ERR=0.
REQ-024 RD0 and RD1 SHALL each drive AR_EN=1, AR_WR=0, AR_AD=latched addr; at the end of RD1 the block SHALL capture AR_DO into RSP_RDATA and enter RSP, RSP_ERR=0.
REQ-025 AR_EN SHALL be 0 in all other states; AR_WR SHALL never be 1 while AR_EN=0.
REQ-026 RSP SHALL hold RSP_VALID=1 and RSP_RDATA/RSP_ERR stable until RSP_READY is sampled 1, then return to IDLE and deassert HALT_REQ in the same transition.
REQ-027 Latency from accept edge T with HALTED already 1: a write SHALL give RSP_VALID at T+3 and a read at T+4 cycles.
REQ-028 HALT_REQ SHALL remain 1 from the HALT state through RSP, including while RSP_READY is held low.
REQ-029 If HALTED drops during WR/RD0/RD1, the access SHALL complete unchanged; the dependency is documented, not detected.

Reset
REQ-030 While RST=1: state=IDLE, CMD_READY=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, HALT_REQ=0, AR_EN=0, AR_WR=0, AR_AD=0, AR_DI=0, and the timeout counter=0.
REQ-031 CMD_READY SHALL rise on the first CLK edge after RST deasserts.
REQ-032 Reset mid-operation SHALL abort immediately (AR_EN/HALT_REQ drop asynchronously) with no response issued for the aborted command.

Configuration
REQ-033 With PEAK_DBG_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entering HALT and increment each HALT cycle with HALTED=0; when it equals TIMEOUT, the block SHALL go to RSP with RSP_ERR=1, RSP_RDATA=0, and no AR access.
REQ-034 Without PEAK_DBG_TIMEOUT_EN, HALT SHALL wait indefinitely, no counter logic SHALL exist, and RSP_ERR SHALL arise only from REQ-020.

Verification
REQ-035 Write: HALTED=1, cmd WR addr 16'h1005 data 32'hDEADBEEF -> exactly one AR_EN&AR_WR cycle with AR_AD=16'h1005, AR_DI=32'hDEADBEEF; RSP_VALID at T+3 with ERR=0.
REQ-036 Read: model returns 32'h12345678 one cycle after AR_EN, addr 16'h1003 -> AR_EN high 2 cycles, RSP_RDATA=32'h12345678 at T+4, ERR=0.
REQ-037 Bad region: cmd addr 16'h2001 -> RSP_ERR=1, RSP_RDATA=0, HALT_REQ and AR_EN never asserted.
REQ-038 Back-pressure: RSP_READY=0 for 10 cycles -> RSP_VALID, data, and HALT_REQ held; CMD_READY=0 until the handshake, then 1 the next cycle.
REQ-039 Timeout (macro on, TIMEOUT=4, HALTED=0) -> RSP_ERR=1 after 4 HALT cycles, no AR_EN; macro off -> no response after 1000 cycles.
REQ-040 Reset asserted during RD1 -> AR_EN=0 and HALT_REQ=0 immediately, RSP_VALID never rises, CMD_READY=1 one edge after release.
